// File: rtl/coproc_mmio_ctrl_if.sv
// CPU-side register bus for the coprocessor front end: word-addressed
// strobes and data, registered read data, and the level interrupt back to the CPU.
interface coproc_mmio_ctrl_if;
    logic [1:0]  addr;
    logic        we;
    logic        re;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    modport master (
        output addr, we, re, wdata,
        input  rdata, irq
    );

    modport slave (
        input  addr, we, re, wdata,
        output rdata, irq
    );
endinterface

// File: rtl/coproc_mmio_ctrl.sv
// MMIO command/status front end for the image coprocessor: turns CMD writes into a
// start pulse plus a held command bundle, times each job, detects hangs, raises irq.
module coproc_mmio_ctrl #(
    parameter int unsigned          CNT_W   = 24,
    parameter logic [CNT_W-1:0]     TIMEOUT = 24'd2000000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    coproc_mmio_ctrl_if.slave       bus,
    output logic                    cp_start,
    output logic [2:0]              cp_func,
    output logic                    cp_gray,
    output logic                    cp_img_idx,
    input  logic                    cp_rdy,
    input  logic                    cp_done
);

    typedef enum logic [1:0] {IDLE, WAIT_RDY, START, BUSY} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
    logic [CNT_W-1:0] cycles, cycles_nxt;
    logic             done_q, done_nxt;
    logic             to_q, to_nxt;
    logic             ovr_q, ovr_nxt;
    logic             ie_q, ie_nxt;
    logic [2:0]       func_nxt;
    logic             gray_nxt, img_nxt;
    logic             irq_q, irq_nxt;
    logic [31:0]      rdata_q, rdata_nxt;
    logic             cmd_wr, st_wr, go;
    logic             unused_wdata;

    assign cmd_wr       = bus.we && (bus.addr == 2'd0);
    assign st_wr        = bus.we && (bus.addr == 2'd1);
    assign go           = cmd_wr && bus.wdata[0];
    assign cnt_inc      = (cnt == '1) ? cnt : cnt + CNT_W'(1);
    assign unused_wdata = ^{bus.wdata[31:9], bus.wdata[7:6]};

    assign cp_start  = (state == START);
    assign bus.rdata = rdata_q;
    assign bus.irq   = irq_q;

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        cycles_nxt = cycles;
        done_nxt   = done_q;
        to_nxt     = to_q;
        ovr_nxt    = ovr_q;
        ie_nxt     = ie_q;
        func_nxt   = cp_func;
        gray_nxt   = cp_gray;
        img_nxt    = cp_img_idx;
        rdata_nxt  = rdata_q;

        if (cmd_wr) ie_nxt = bus.wdata[8];

        // W1C clears are applied first so a hardware set in the same cycle overrides them
        if (st_wr) begin
            if (bus.wdata[1]) done_nxt = 1'b0;
            if (bus.wdata[2]) to_nxt   = 1'b0;
            if (bus.wdata[3]) ovr_nxt  = 1'b0;
        end

        unique case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (go) begin
                    state_nxt = cp_rdy ? START : WAIT_RDY;
                    func_nxt  = bus.wdata[3:1];
                    gray_nxt  = bus.wdata[4];
                    img_nxt   = bus.wdata[5];
                end
            end
            WAIT_RDY: begin
                cnt_nxt = '0;
                if (cp_rdy) state_nxt = START;
            end
            START: begin
                cnt_nxt   = cnt_inc;
                state_nxt = BUSY;
            end
            BUSY: begin
                cnt_nxt = cnt_inc;
                if (cp_done) begin
                    cycles_nxt = cnt + CNT_W'(1);
                    done_nxt   = 1'b1;
                    state_nxt  = IDLE;
                end else if (cnt == TIMEOUT - CNT_W'(1)) begin
                    cycles_nxt = TIMEOUT;
                    to_nxt     = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (go && (state != IDLE)) ovr_nxt = 1'b1;

        // Reads sample the pre-write register values
        if (bus.re) begin
            unique case (bus.addr)
                2'd0:    rdata_nxt = {23'b0, ie_q, 2'b0, cp_img_idx, cp_gray, cp_func, 1'b0};
                2'd1:    rdata_nxt = {27'b0, cp_rdy, ovr_q, to_q, done_q, state != IDLE};
                2'd2:    rdata_nxt = 32'(cycles);
                default: rdata_nxt = '0;
            endcase
        end

        irq_nxt = ie_nxt & (done_nxt | to_nxt);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            cycles     <= '0;
            done_q     <= 1'b0;
            to_q       <= 1'b0;
            ovr_q      <= 1'b0;
            ie_q       <= 1'b0;
            cp_func    <= '0;
            cp_gray    <= 1'b0;
            cp_img_idx <= 1'b0;
            irq_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            cycles     <= cycles_nxt;
            done_q     <= done_nxt;
            to_q       <= to_nxt;
            ovr_q      <= ovr_nxt;
            ie_q       <= ie_nxt;
            cp_func    <= func_nxt;
            cp_gray    <= gray_nxt;
            cp_img_idx <= img_nxt;
            irq_q      <= irq_nxt;
            rdata_q    <= rdata_nxt;
        end
    end

endmodule

// File: tb/tb_coproc_mmio_ctrl.sv
// Scoreboard bench for coproc_mmio_ctrl: reads and start pulses are queued with their
// expected values at issue time and checked by independent monitor processes.
module tb_coproc_mmio_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, rst_to_n;
    logic [1:0]  addr;
    logic        we, re;
    logic [31:0] wdata;
    logic        cp_rdy, cp_done;

    logic        cp_start0, cp_gray0, cp_img0;
    logic [2:0]  cp_func0;
    logic        cp_start1, cp_gray1, cp_img1;
    logic [2:0]  cp_func1;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int          rq_id[$];
    logic [31:0] rq_exp[$];
    string       rq_name[$];
    int          sq[$];

    coproc_mmio_ctrl_if bus0 ();
    coproc_mmio_ctrl_if bus1 ();

    assign bus0.addr  = addr;
    assign bus0.we    = we;
    assign bus0.re    = re;
    assign bus0.wdata = wdata;
    assign bus1.addr  = addr;
    assign bus1.we    = we;
    assign bus1.re    = re;
    assign bus1.wdata = wdata;

    coproc_mmio_ctrl dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0),
        .cp_start(cp_start0), .cp_func(cp_func0), .cp_gray(cp_gray0),
        .cp_img_idx(cp_img0), .cp_rdy(cp_rdy), .cp_done(cp_done)
    );

    coproc_mmio_ctrl #(.TIMEOUT(24'd100)) dut1 (
        .clk(clk), .rst_n(rst_to_n), .bus(bus1),
        .cp_start(cp_start1), .cp_func(cp_func1), .cp_gray(cp_gray1),
        .cp_img_idx(cp_img1), .cp_rdy(cp_rdy), .cp_done(cp_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Read monitor: rdata is registered on the edge where re is sampled
    always @(posedge clk) begin : rd_mon
        int          id;
        logic [31:0] e;
        string       n;
        if (re) begin
            if (rq_exp.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected: read at cycle %0d with no expectation queued", cyc);
            end else begin
                id = rq_id.pop_front();
                e  = rq_exp.pop_front();
                n  = rq_name.pop_front();
                #1;
                check(n, (id == 1) ? bus1.rdata : bus0.rdata, e);
            end
        end
    end

    // Start monitor: every pulse must match a queued cycle; a second pulse finds the queue empty
    always @(negedge clk) begin
        if (cp_start0 === 1'b1) begin
            if (sq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL cp_start_unexpected: pulse at cycle %0d, none expected", cyc);
            end else begin
                check("cp_start_cycle", cyc, sq.pop_front());
            end
        end
    end

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        addr = a; wdata = d; we = 1'b1;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic rd(input int id, input logic [1:0] a, input logic [31:0] e, input string n);
        rq_id.push_back(id); rq_exp.push_back(e); rq_name.push_back(n);
        addr = a; re = 1'b1;
        @(negedge clk);
        re = 1'b0;
    endtask

    task automatic rdwr(input int id, input logic [1:0] a, input logic [31:0] d,
                        input logic [31:0] e, input string n);
        rq_id.push_back(id); rq_exp.push_back(e); rq_name.push_back(n);
        addr = a; wdata = d; re = 1'b1; we = 1'b1;
        @(negedge clk);
        re = 1'b0; we = 1'b0;
    endtask

    task automatic done_pulse();
        cp_done = 1'b1;
        @(negedge clk);
        cp_done = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; rst_to_n = 1'b0;
        addr = '0; we = 1'b0; re = 1'b0; wdata = '0;
        cp_rdy = 1'b1; cp_done = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_irq", {31'b0, bus0.irq}, 32'h0);
        check("rst_cp_start", {31'b0, cp_start0}, 32'h0);
        check("rst_rdata", bus0.rdata, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        rd(0, 2'd1, 32'h10, "rst_status");
        rd(0, 2'd2, 32'h0,  "rst_cycles");
        rd(0, 2'd0, 32'h0,  "rst_cmd");

        // Job with done 100 cycles after start
        sq.push_back(cyc + 1);
        wr(2'd0, 32'h10F);
        repeat (99) @(negedge clk);
        check("job1_func_held", {29'b0, cp_func0}, 32'd7);
        @(negedge clk);
        done_pulse();
        check("job1_irq", {31'b0, bus0.irq}, 32'h1);
        rd(0, 2'd1, 32'h12,  "job1_status");
        rd(0, 2'd2, 32'd101, "job1_cycles");
        rd(0, 2'd0, 32'h10E, "job1_cmd");
        wr(2'd1, 32'h2);
        check("job1_irq_clr", {31'b0, bus0.irq}, 32'h0);
        rd(0, 2'd1, 32'h10, "job1_status_clr");

        // go while cp_rdy is low waits without starting
        cp_rdy = 1'b0;
        wr(2'd0, 32'h025);
        repeat (48) @(negedge clk);
        rd(0, 2'd1, 32'h01, "wait_status");
        sq.push_back(cyc + 1);
        cp_rdy = 1'b1;
        @(negedge clk);
        check("wait_func", {29'b0, cp_func0}, 32'd2);
        check("wait_img", {31'b0, cp_img0}, 32'h1);
        check("wait_gray", {31'b0, cp_gray0}, 32'h0);
        repeat (9) @(negedge clk);
        done_pulse();
        check("wait_irq_off", {31'b0, bus0.irq}, 32'h0);
        rd(0, 2'd2, 32'd10, "wait_cycles");
        rd(0, 2'd0, 32'h24, "wait_cmd");
        rdwr(0, 2'd1, 32'h2, 32'h12, "rdwr_prewrite");
        rd(0, 2'd1, 32'h10, "raw_status");

        // Overrun, plus W1C of done colliding with a done set
        sq.push_back(cyc + 1);
        wr(2'd0, 32'h10B);
        wr(2'd0, 32'h107);
        check("ovr_func", {29'b0, cp_func0}, 32'd5);
        rd(0, 2'd1, 32'h19, "ovr_status_busy");
        addr = 2'd1; wdata = 32'h2; we = 1'b1; cp_done = 1'b1;
        @(negedge clk);
        we = 1'b0; cp_done = 1'b0;
        rd(0, 2'd1, 32'h1A, "ovr_set_wins");
        rd(0, 2'd2, 32'd3,  "ovr_cycles");
        check("ovr_irq", {31'b0, bus0.irq}, 32'h1);
        wr(2'd1, 32'hE);
        check("ovr_irq_clr", {31'b0, bus0.irq}, 32'h0);
        done_pulse();
        rd(0, 2'd1, 32'h10, "idle_done_ignored");
        wr(2'd3, 32'hFFFF_FFFF);
        rd(0, 2'd3, 32'h0, "addr3_read");
        wr(2'd2, 32'h1234);
        rd(0, 2'd2, 32'd3, "cycles_ro");

        // Timeout on the TIMEOUT=100 instance
        rst_n = 1'b0; rst_to_n = 1'b1;
        repeat (2) @(negedge clk);
        wr(2'd0, 32'h101);
        check("to_cp_start", {31'b0, cp_start1}, 32'h1);
        repeat (98) @(negedge clk);
        check("to_irq_k98", {31'b0, bus1.irq}, 32'h0);
        @(negedge clk);
        check("to_irq_k99", {31'b0, bus1.irq}, 32'h0);
        @(negedge clk);
        check("to_irq_k100", {31'b0, bus1.irq}, 32'h1);
        rd(1, 2'd1, 32'h14,  "to_status");
        rd(1, 2'd2, 32'd100, "to_cycles");
        done_pulse();
        rd(1, 2'd1, 32'h14, "to_late_done");
        wr(2'd1, 32'h4);
        wr(2'd0, 32'h101);
        repeat (99) @(negedge clk);
        done_pulse();
        rd(1, 2'd1, 32'h12,  "to_done_wins");
        rd(1, 2'd2, 32'd100, "to_done_cycles");

        // Reset in the middle of BUSY
        rst_to_n = 1'b0; rst_n = 1'b1;
        repeat (2) @(negedge clk);
        sq.push_back(cyc + 1);
        wr(2'd0, 32'h13F);
        repeat (5) @(negedge clk);
        rd(0, 2'd1, 32'h11, "busy_status");
        check("busy_func", {29'b0, cp_func0}, 32'd7);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_start", {31'b0, cp_start0}, 32'h0);
        check("mid_rst_irq", {31'b0, bus0.irq}, 32'h0);
        check("mid_rst_cmd", {27'b0, cp_img0, cp_gray0, cp_func0}, 32'h0);
        check("mid_rst_rdata", bus0.rdata, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        done_pulse();
        rd(0, 2'd1, 32'h10, "post_rst_status");
        check("post_rst_irq", {31'b0, bus0.irq}, 32'h0);

        repeat (3) @(negedge clk);
        if (rq_exp.size() != 0 || sq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL pending: %0d reads and %0d start pulses never observed",
                     rq_exp.size(), sq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/coproc_mmio_ctrl.md
Name: coproc_mmio_ctrl

Overview:
- CPU-facing command and status front end that sits directly upstream of the image coprocessor.
- Converts memory-mapped register writes from the RISC-V core into the coprocessor's command bundle (func, gray, img_idx) and a single-cycle start pulse.
- Tracks the coprocessor's rdy/done handshake, measures job latency, detects hangs, and raises a level interrupt on completion or timeout.

Parameters:
- CNT_W, 24: width of the cycle counter and of the timeout compare.
- TIMEOUT, 24'd2000000: number of cycles in BUSY before the job is aborted as hung. Must be ≥ 2 and < 2^CNT_W.

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  synchronous active-low reset.
- addr  in  2  word address of the register: 0 CMD, 1 STATUS, 2 CYCLES, 3 reserved.
- we  in  1  write strobe, one cycle.
- re  in  1  read strobe, one cycle.
- wdata  in  32  write data.
- rdata  out  32  read data, registered.
- irq  out  1  level interrupt to the CPU.
- cp_start  out  1  one-cycle active-high start pulse to the coprocessor.
- cp_func  out  3  filter/function select, held stable for the whole job.
- cp_gray  out  1  grayscale mode, held stable for the whole job.
- cp_img_idx  out  1  source image select, held stable for the whole job.
- cp_rdy  in  1  coprocessor is idle and can accept a start.
- cp_done  in  1  coprocessor job-complete pulse.

Behaviour:
- Reset (rst_n=0 sampled at posedge clk) clears all outputs and state:
  - rdata, irq, cp_start, cp_func, cp_gray, cp_img_idx all 0.
  - FSM returns to IDLE; STATUS bits, CYCLES, and the ie bit clear to 0.
  - Reset mid-job drops cp_start and aborts tracking at that edge; a later cp_done is ignored.
- CMD write (addr 0), register fields:
  - [0] go: self-clearing, always reads 0.
  - [3:1] func, [4] gray, [5] img_idx, [8] ie (interrupt enable).
  - Writing ie is always accepted.
  - A go=1 write in IDLE latches func/gray/img_idx into cp_* on that edge.
  - A go=1 write in any other state is ignored, cp_* stay unchanged, and STATUS.overrun is set.
- CMD read returns {23'b0, ie, 2'b0, img_idx, gray, func, 1'b0}.
- FSM states:
  - IDLE --go--> START if cp_rdy=1 that cycle, else WAIT_RDY.
  - WAIT_RDY --cp_rdy=1--> START. There is no timeout in this state.
  - START: cp_start=1 for exactly this one cycle; the cycle counter clears to 0; next state is BUSY.
  - BUSY: the counter increments each cycle and saturates at all-ones.
    - cp_done=1: CYCLES ← counter+1, STATUS.done set, next state IDLE.
    - Counter reaches TIMEOUT-1 without cp_done: CYCLES ← TIMEOUT, STATUS.timeout set, next state IDLE.
  - Minimum go-to-start latency with cp_rdy high: cp_start is asserted in the cycle after the write edge.
- STATUS (addr 1):
  - Read returns bits [0] busy (state≠IDLE), [1] done, [2] timeout, [3] overrun, [4] cp_rdy (live value).
  - Write is write-1-to-clear for bits [3:1]; writes to bits 0 and 4 are ignored.
- CYCLES (addr 2): read-only, holds the last job's latency measured from the start pulse through done inclusive. Writes are ignored.
- Address 3: reads 0; writes are ignored.
- Reads: rdata updates on the edge where re=1 and holds its value otherwise.
  - Read-after-write to the same register in consecutive cycles returns the new value.
  - Simultaneous re and we in one cycle: the read returns the pre-write value.
- irq = ie & (done | timeout), registered. It deasserts the cycle after the status bits are cleared or ie is cleared.
- Simultaneous events:
  - cp_done in the same cycle as the timeout compare: done wins, timeout is not set.
  - A W1C clear in the same cycle as a hardware set of the same bit: the set wins.
  - cp_done outside BUSY: ignored.
  - go write in the same edge the FSM returns to IDLE: the FSM is still not in IDLE, so the write counts as an overrun.

Test Plan:
- Reset, then read STATUS with cp_rdy=1 → rdata=0x10. CYCLES reads 0. irq=0 and cp_start=0.
- Write CMD=0x10F (ie=1, func=7, go=1) with cp_rdy=1; model asserts cp_done 100 cycles after cp_start →
  - cp_start high for exactly one cycle, the cycle after the write.
  - cp_func=7 held until done.
  - STATUS=0x12, CYCLES=101, irq=1.
  - Then W1C 0x2 to STATUS → irq=0 next cycle.
- Hold cp_rdy=0 for 50 cycles after go with CMD=0x025 (func=2, gray=0, img_idx=1) → FSM stays in WAIT_RDY with busy=1 and no cp_start. cp_start fires the cycle after cp_rdy rises.
- TIMEOUT=100, ie=1, no cp_done → STATUS.timeout=1, CYCLES=100, irq=1, busy=0. A cp_done arriving later changes nothing.
- Second go during BUSY with a different func → overrun=1, cp_func unchanged, exactly one cp_start observed.
- Assert rst_n=0 in the middle of BUSY → all outputs 0 next edge. A following cp_done does not set done.
